// File: rtl/spi_eeprom_responder.sv
// SPI mode-0 responder emulating a 25xx-style EEPROM, with a host load port.
// Define SPI_EEPROM_WRITE_EN to add WREN/WRDI/WRITE/RDSR and the WEL bit.
module spi_eeprom_responder #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sck,
  input  logic              cs_n,
  input  logic              copi,
  output logic              cipo,
  output logic              cipo_oe,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [7:0]        load_data,
  output logic              busy
);
  localparam int SH_W = (ADDR_W > 8) ? ADDR_W - 1 : 7;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_ADDR,
    S_RDATA,
    S_IGNORE,
    S_WDATA,
    S_STATUS
  } state_t;

  state_t r_state;
  state_t w_state_n;

  logic [1:0] r_sck_s;
  logic [1:0] r_cs_s;
  logic [1:0] r_copi_s;
  logic       r_sck_d;
  logic       w_cs;
  logic       w_copi;
  logic       w_rise;
  logic       w_fall;

  logic [SH_W-1:0]   r_sh;
  logic [SH_W:0]     w_sh_next;
  logic [3:0]        r_cnt;
  logic [ADDR_W-1:0] r_addr;
  logic [7:0]        r_rdata;
  logic [7:0]        r_obyte;
  logic [7:0]        w_src;
  logic              r_cipo;
  logic              w_op_end;
  logic              w_addr_end;

  logic              w_we;
  logic [ADDR_W-1:0] w_wa;
  logic [7:0]        w_wd;
  logic [7:0]        r_mem [2**ADDR_W];

`ifdef SPI_EEPROM_WRITE_EN
  logic r_wel;
  logic r_wel_set;
  logic r_wel_clr;
  logic r_is_wr;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sck_s  <= 2'b00;
      r_cs_s   <= 2'b11;
      r_copi_s <= 2'b00;
      r_sck_d  <= 1'b0;
    end else begin
      r_sck_s  <= {r_sck_s[0], sck};
      r_cs_s   <= {r_cs_s[0], cs_n};
      r_copi_s <= {r_copi_s[0], copi};
      r_sck_d  <= r_sck_s[1];
    end
  end

  assign w_cs      = r_cs_s[1];
  assign w_copi    = r_copi_s[1];
  assign w_rise    = r_sck_s[1] & ~r_sck_d;
  assign w_fall    = ~r_sck_s[1] & r_sck_d;
  assign w_sh_next = {r_sh, w_copi};

  assign w_op_end   = (r_state == S_CMD) & w_rise & (r_cnt == 4'd7);
  assign w_addr_end = (r_state == S_ADDR) & w_rise & (r_cnt == 4'd15);

  assign busy    = ~w_cs;
  assign cipo_oe = (r_state == S_RDATA) | (r_state == S_STATUS);
  assign cipo    = r_cipo & cipo_oe;

`ifdef SPI_EEPROM_WRITE_EN
  assign w_src = (r_state == S_STATUS) ? {6'b0, r_wel, 1'b0} : r_rdata;
`else
  assign w_src = r_rdata;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_n;
  end

  // A deasserted chip select overrides everything, including same-cycle sck edges.
  always_comb begin
    w_state_n = r_state;
    if (w_cs) begin
      w_state_n = S_IDLE;
    end else begin
      unique case (r_state)
        S_IDLE: w_state_n = S_CMD;
        S_CMD: begin
          if (w_op_end) begin
            unique case (w_sh_next[7:0])
              8'h03:   w_state_n = S_ADDR;
`ifdef SPI_EEPROM_WRITE_EN
              8'h02:   w_state_n = S_ADDR;
              8'h05:   w_state_n = S_STATUS;
`endif
              default: w_state_n = S_IGNORE;
            endcase
          end
        end
        S_ADDR: begin
          if (w_addr_end) begin
`ifdef SPI_EEPROM_WRITE_EN
            w_state_n = r_is_wr ? S_WDATA : S_RDATA;
`else
            w_state_n = S_RDATA;
`endif
          end
        end
        default: w_state_n = r_state;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sh    <= '0;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_obyte <= '0;
      r_cipo  <= 1'b0;
    end else if (w_cs) begin
      r_cnt  <= '0;
      r_cipo <= 1'b0;
    end else begin
      unique case (r_state)
        S_CMD, S_ADDR, S_WDATA: begin
          if (w_rise) begin
            r_sh  <= w_sh_next[SH_W-1:0];
            r_cnt <= r_cnt + 4'd1;
            if (w_op_end) r_cnt <= '0;
            if (w_addr_end) begin
              r_cnt  <= '0;
              r_addr <= w_sh_next[ADDR_W-1:0];
            end
            if (r_state == S_WDATA && r_cnt == 4'd7) begin
              r_cnt  <= '0;
              r_addr <= r_addr + ADDR_W'(1);
            end
          end
        end
        S_RDATA, S_STATUS: begin
          if (w_fall) begin
            r_cnt <= {1'b0, r_cnt[2:0] + 3'd1};
            // Bit 7 comes straight from the prefetched byte; the rest shift out.
            if (r_cnt[2:0] == 3'd0) begin
              r_cipo  <= w_src[7];
              r_obyte <= {w_src[6:0], 1'b0};
              if (r_state == S_RDATA) r_addr <= r_addr + ADDR_W'(1);
            end else begin
              r_cipo  <= r_obyte[7];
              r_obyte <= {r_obyte[6:0], 1'b0};
            end
          end
        end
        default: ;
      endcase
    end
  end

`ifdef SPI_EEPROM_WRITE_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wel     <= 1'b0;
      r_wel_set <= 1'b0;
      r_wel_clr <= 1'b0;
      r_is_wr   <= 1'b0;
    end else if (w_cs) begin
      if (r_wel_set)      r_wel <= 1'b1;
      else if (r_wel_clr) r_wel <= 1'b0;
      r_wel_set <= 1'b0;
      r_wel_clr <= 1'b0;
      r_is_wr   <= 1'b0;
    end else if (w_op_end) begin
      r_wel_set <= (w_sh_next[7:0] == 8'h06);
      r_wel_clr <= (w_sh_next[7:0] == 8'h04) |
                   (w_sh_next[7:0] == 8'h02);
      r_is_wr   <= (w_sh_next[7:0] == 8'h02);
    end else if (w_rise) begin
      r_wel_set <= 1'b0;
    end
  end
`endif

  always_comb begin
    w_we = load_en & w_cs;
    w_wa = load_addr;
    w_wd = load_data;
`ifdef SPI_EEPROM_WRITE_EN
    if (r_state == S_WDATA && !w_cs && w_rise && r_cnt == 4'd7) begin
      w_we = r_wel;
      w_wa = r_addr;
      w_wd = w_sh_next[7:0];
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (w_we) r_mem[w_wa] <= w_wd;
    r_rdata <= r_mem[r_addr];
  end

endmodule

// File: tb/tb_spi_eeprom_responder.sv
// Self-checking bench for spi_eeprom_responder against a byte-array model.
// Write-path scenarios are included when SPI_EEPROM_WRITE_EN is defined.
module tb_spi_eeprom_responder;
  localparam int AW = 10;
  localparam int DEPTH = 1024;
  localparam int H = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          sck = 1'b0;
  logic          cs_n = 1'b1;
  logic          copi = 1'b0;
  logic          load_en = 1'b0;
  logic [AW-1:0] load_addr = '0;
  logic [7:0]    load_data = '0;
  logic          cipo;
  logic          cipo_oe;
  logic          busy;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] model [DEPTH];
  logic [7:0] rxb [16];
  logic       rxoe [16];
`ifdef SPI_EEPROM_WRITE_EN
  logic       wel_m = 1'b0;
`endif

  always #5 clk = ~clk;

  spi_eeprom_responder #(.ADDR_W(AW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sck       (sck),
    .cs_n      (cs_n),
    .copi      (copi),
    .cipo      (cipo),
    .cipo_oe   (cipo_oe),
    .load_en   (load_en),
    .load_addr (load_addr),
    .load_data (load_data),
    .busy      (busy)
  );

  task automatic clk_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic load(input logic [AW-1:0] a, input logic [7:0] d);
    @(negedge clk);
    load_en = 1'b1;
    load_addr = a;
    load_data = d;
    @(negedge clk);
    load_en = 1'b0;
    model[a] = d;
  endtask

  task automatic spi_bits(input logic [7:0] tx, input int nb,
                          output logic [7:0] rx, output logic oe_all,
                          output logic oe_any);
    rx = '0;
    oe_all = 1'b1;
    oe_any = 1'b0;
    for (int i = 7; i >= 8 - nb; i--) begin
      copi = tx[i];
      clk_n(H);
      rx[i] = cipo;
      oe_all = oe_all & cipo_oe;
      oe_any = oe_any | cipo_oe;
      sck = 1'b1;
      clk_n(H);
      sck = 1'b0;
    end
  endtask

  task automatic cs_begin();
    cs_n = 1'b0;
    clk_n(H);
  endtask

  task automatic cs_end();
    clk_n(H);
    cs_n = 1'b1;
    clk_n(3 * H);
  endtask

  task automatic spi_read(input logic [15:0] a, input int n);
    logic [7:0] d;
    logic oa, on;
    cs_begin();
    spi_bits(8'h03, 8, d, oa, on);
    spi_bits(a[15:8], 8, d, oa, on);
    spi_bits(a[7:0], 8, d, oa, on);
    for (int k = 0; k < n; k++) begin
      spi_bits(8'h00, 8, d, oa, on);
      rxb[k] = d;
      rxoe[k] = oa;
    end
    cs_end();
  endtask

  function automatic int exp_idx(input logic [15:0] a, input int k);
    return (int'(a) + k) % DEPTH;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    clk_n(5);
    rst_n = 1'b1;
    clk_n(2);
    n_cmp++;
    if (cipo !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_cipo: got %b want 0", cipo);
    end
    n_cmp++;
    if (cipo_oe !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_oe: got %b want 0", cipo_oe);
    end
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_busy: got %b want 0", busy);
    end
  endtask

  task automatic test_fill();
    for (int i = 0; i < DEPTH; i++) load(AW'(i), 8'($urandom));
  endtask

  task automatic test_plan_read();
    logic [7:0] want [4];
    want[0] = 8'h00;
    want[1] = 8'h10;
    want[2] = 8'h00;
    want[3] = 8'h20;
    for (int i = 0; i < 4; i++) load(AW'(i), want[i]);
    spi_read(16'h0000, 4);
    for (int k = 0; k < 4; k++) begin
      n_cmp++;
      if (rxb[k] !== want[k]) begin
        n_bad++;
        $display("FAIL plan_byte%0d: got %h want %h", k, rxb[k], want[k]);
      end
      n_cmp++;
      if (rxoe[k] !== 1'b1) begin
        n_bad++;
        $display("FAIL plan_oe%0d: got %b want 1", k, rxoe[k]);
      end
    end
  endtask

  task automatic test_wrap();
    load(10'h3FF, 8'hA5);
    load(10'h000, 8'h5A);
    spi_read(16'h03FF, 2);
    n_cmp++;
    if (rxb[0] !== 8'hA5) begin
      n_bad++;
      $display("FAIL wrap_top: got %h want a5", rxb[0]);
    end
    n_cmp++;
    if (rxb[1] !== 8'h5A) begin
      n_bad++;
      $display("FAIL wrap_zero: got %h want 5a", rxb[1]);
    end
  endtask

  task automatic test_high_addr();
    spi_read(16'hFC02, 1);
    n_cmp++;
    if (rxb[0] !== model[2]) begin
      n_bad++;
      $display("FAIL high_addr: got %h want %h", rxb[0], model[2]);
    end
  endtask

  task automatic test_abort();
    logic [7:0] d;
    logic oa, on;
    cs_begin();
    spi_bits(8'h03, 8, d, oa, on);
    spi_bits(8'h00, 8, d, oa, on);
    spi_bits(8'h00, 8, d, oa, on);
    spi_bits(8'h00, 4, d, oa, on);
    n_cmp++;
    if (d[7:4] !== model[0][7:4]) begin
      n_bad++;
      $display("FAIL abort_partial: got %h want %h", d[7:4], model[0][7:4]);
    end
    cs_end();
    n_cmp++;
    if (cipo_oe !== 1'b0) begin
      n_bad++;
      $display("FAIL abort_oe: got %b want 0", cipo_oe);
    end
    n_cmp++;
    if (cipo !== 1'b0) begin
      n_bad++;
      $display("FAIL abort_cipo: got %b want 0", cipo);
    end
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++;
      $display("FAIL abort_busy: got %b want 0", busy);
    end
    spi_read(16'h0001, 1);
    n_cmp++;
    if (rxb[0] !== model[1]) begin
      n_bad++;
      $display("FAIL abort_reread: got %h want %h", rxb[0], model[1]);
    end
  endtask

  task automatic test_ignore();
    logic [7:0] d0, d1;
    logic oa, on0, on1;
    cs_begin();
    spi_bits(8'h9F, 8, d0, oa, on0);
    n_cmp++;
    if (busy !== 1'b1) begin
      n_bad++;
      $display("FAIL ignore_busy: got %b want 1", busy);
    end
    @(negedge clk);
    load_en = 1'b1;
    load_addr = 10'h001;
    load_data = ~model[1];
    @(negedge clk);
    load_en = 1'b0;
    spi_bits(8'hFF, 8, d0, oa, on0);
    spi_bits(8'h00, 8, d1, oa, on1);
    n_cmp++;
    if ((on0 | on1) !== 1'b0) begin
      n_bad++;
      $display("FAIL ignore_oe: got %b want 0", on0 | on1);
    end
    n_cmp++;
    if ({d0, d1} !== 16'h0000) begin
      n_bad++;
      $display("FAIL ignore_cipo: got %h want 0000", {d0, d1});
    end
    cs_end();
    spi_read(16'h0001, 1);
    n_cmp++;
    if (rxb[0] !== model[1]) begin
      n_bad++;
      $display("FAIL busy_load: got %h want %h", rxb[0], model[1]);
    end
  endtask

  task automatic test_random_reads();
    logic [15:0] a;
    int n;
    for (int t = 0; t < 10; t++) begin
      a = 16'($urandom_range(0, 65535));
      if (t == 0) a = 16'hFFFE;
      n = $urandom_range(1, 5);
      spi_read(a, n);
      for (int k = 0; k < n; k++) begin
        n_cmp++;
        if (rxb[k] !== model[exp_idx(a, k)]) begin
          n_bad++;
          $display("FAIL rand_read a=%h k=%0d: got %h want %h",
                   a, k, rxb[k], model[exp_idx(a, k)]);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [AW-1:0] a;
    logic [7:0] d;
    for (int t = 0; t < 4; t++) begin
      a = AW'($urandom);
      d = 8'($urandom);
      load(a, d);
      spi_read({6'($urandom), a}, 2);
      n_cmp++;
      if (rxb[0] !== d) begin
        n_bad++;
        $display("FAIL b2b_first a=%h: got %h want %h", a, rxb[0], d);
      end
      n_cmp++;
      if (rxb[1] !== model[(int'(a) + 1) % DEPTH]) begin
        n_bad++;
        $display("FAIL b2b_next a=%h: got %h want %h", a, rxb[1],
                 model[(int'(a) + 1) % DEPTH]);
      end
    end
  endtask

`ifdef SPI_EEPROM_WRITE_EN
  task automatic spi_cmd(input logic [7:0] op);
    logic [7:0] d;
    logic oa, on;
    cs_begin();
    spi_bits(op, 8, d, oa, on);
    cs_end();
  endtask

  task automatic spi_write(input logic [15:0] a, input logic [7:0] v);
    logic [7:0] d;
    logic oa, on;
    cs_begin();
    spi_bits(8'h02, 8, d, oa, on);
    spi_bits(a[15:8], 8, d, oa, on);
    spi_bits(a[7:0], 8, d, oa, on);
    spi_bits(v, 8, d, oa, on);
    cs_end();
    if (wel_m) model[a[AW-1:0]] = v;
    wel_m = 1'b0;
  endtask

  task automatic spi_rdsr(output logic [7:0] s0, output logic [7:0] s1);
    logic [7:0] d;
    logic oa, on;
    cs_begin();
    spi_bits(8'h05, 8, d, oa, on);
    spi_bits(8'h00, 8, s0, oa, on);
    spi_bits(8'h00, 8, s1, oa, on);
    cs_end();
  endtask

  task automatic test_write();
    logic [7:0] s0, s1;
    load(10'h010, 8'h11);
    spi_write(16'h0010, 8'h77);
    spi_read(16'h0010, 1);
    n_cmp++;
    if (rxb[0] !== model[16]) begin
      n_bad++;
      $display("FAIL write_no_wren: got %h want %h", rxb[0], model[16]);
    end
    spi_cmd(8'h06);
    wel_m = 1'b1;
    spi_rdsr(s0, s1);
    n_cmp++;
    if ({s0, s1} !== {2{6'b0, wel_m, 1'b0}}) begin
      n_bad++;
      $display("FAIL rdsr_wel: got %h want %h", {s0, s1},
               {2{6'b0, wel_m, 1'b0}});
    end
    spi_write(16'h0010, 8'hC3);
    spi_read(16'h0010, 1);
    n_cmp++;
    if (rxb[0] !== 8'hC3) begin
      n_bad++;
      $display("FAIL write_data: got %h want c3", rxb[0]);
    end
    spi_rdsr(s0, s1);
    n_cmp++;
    if (s0 !== 8'h00) begin
      n_bad++;
      $display("FAIL rdsr_cleared: got %h want 00", s0);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_fill();
    test_plan_read();
    test_wrap();
    test_high_addr();
    test_abort();
    test_ignore();
    test_random_reads();
    test_back_to_back();
`ifdef SPI_EEPROM_WRITE_EN
    test_write();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
